// File: rtl/vend_if.sv
// vend_if: signal bundle between the vending controller and its environment.
//   cash_in[1:0]       coin event (00 none, 01 5Tk, 10 10Tk, 11 20Tk)
//   select[1:0]        request (00 none, 01 A, 10 B, 11 cancel)
//   disp_req/disp_item dispense request and item code; disp_ack acknowledges it
//   chg_req/chg_coin   change-coin request and coin code; chg_ack acknowledges it
//   credit[5:0]        current credit in Tk
//   coin_reject        one-cycle pulse, previous coin returned
//   present_state[1:0] IDLE=00, CREDIT=01, VEND=10, CHANGE=11
// Modport slave is the controller side, master is the environment side.
interface vend_if;
   logic [1:0] cash_in;
   logic [1:0] select;
   logic       disp_req;
   logic [1:0] disp_item;
   logic       disp_ack;
   logic       chg_req;
   logic [1:0] chg_coin;
   logic       chg_ack;
   logic [5:0] credit;
   logic       coin_reject;
   logic [1:0] present_state;

   modport master (
      output cash_in, select, disp_ack, chg_ack,
      input  disp_req, disp_item, chg_req, chg_coin, credit, coin_reject, present_state
   );

   modport slave (
      input  cash_in, select, disp_ack, chg_ack,
      output disp_req, disp_item, chg_req, chg_coin, credit, coin_reject, present_state
   );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: coin-operated vending controller with two products, a credit
// ceiling and coin-by-coin change return.
// Ports:
//   clk_i  - single clock, all state updates on its rising edge
//   rst_ni - synchronous active-low reset
//   bus    - vend_if.slave: coins/selects/acks in, dispense/change/status out
// Optional feature: define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYC
// consecutive CREDIT cycles without a coin or select; otherwise CREDIT is held.
// All outputs come straight from registers.
module vend_controller #(
   parameter int unsigned PRICE_A     = 10,
   parameter int unsigned PRICE_B     = 15,
   parameter int unsigned MAX_CREDIT  = 40,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input logic clk_i,
   input logic rst_ni,
   vend_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StCredit = 2'b01,
      StVend   = 2'b10,
      StChange = 2'b11
   } state_e;

   localparam logic [5:0] PriceA    = 6'(PRICE_A);
   localparam logic [5:0] PriceB    = 6'(PRICE_B);
   localparam logic [6:0] MaxCredit = 7'(MAX_CREDIT);

   state_e     state_q, state_d;
   logic [5:0] credit_q, credit_d;
   logic [1:0] item_q, item_d;
   logic       disp_req_q, disp_req_d;
   logic [1:0] disp_item_q, disp_item_d;
   logic       chg_req_q, chg_req_d;
   logic [1:0] chg_coin_q, chg_coin_d;
   logic       coin_reject_q, coin_reject_d;

   logic [6:0] coin_val;
   logic [6:0] coin_sum;
   logic       sel_taken;
   logic       chg_taken;
   logic       no_event;

   assign no_event = (bus.cash_in == 2'b00) && (bus.select == 2'b00);

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            tmo_hit;

   // Hit on the idle cycle that brings the count up to TIMEOUT_CYC.
   assign tmo_hit = (state_q == StCredit) && no_event &&
                    (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == StCredit && no_event && !tmo_hit) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   always_comb begin
      coin_val = 7'd0;
      unique case (bus.cash_in)
         2'b01:   coin_val = 7'd5;
         2'b10:   coin_val = 7'd10;
         2'b11:   coin_val = 7'd20;
         default: coin_val = 7'd0;
      endcase
   end

   // Seven bits so an overflowing coin is detected rather than wrapped.
   assign coin_sum = {1'b0, credit_q} + coin_val;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         item_q        <= '0;
         disp_req_q    <= 1'b0;
         disp_item_q   <= '0;
         chg_req_q     <= 1'b0;
         chg_coin_q    <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         item_q        <= item_d;
         disp_req_q    <= disp_req_d;
         disp_item_q   <= disp_item_d;
         chg_req_q     <= chg_req_d;
         chg_coin_q    <= chg_coin_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      item_d        = item_q;
      coin_reject_d = 1'b0;
      sel_taken     = 1'b0;
      chg_taken     = 1'b0;
      unique case (state_q)
         StIdle, StCredit: begin
            // Select is judged on the pre-coin credit; it wins over a same-cycle coin.
            if (state_q == StCredit) begin
               if (bus.select == 2'b01 && credit_q >= PriceA) begin
                  item_d    = 2'b01;
                  state_d   = StVend;
                  sel_taken = 1'b1;
               end else if (bus.select == 2'b10 && credit_q >= PriceB) begin
                  item_d    = 2'b10;
                  state_d   = StVend;
                  sel_taken = 1'b1;
               end else if (bus.select == 2'b11) begin
                  state_d   = StChange;
                  sel_taken = 1'b1;
               end
            end
            if (bus.cash_in != 2'b00) begin
               if (sel_taken || coin_sum > MaxCredit) begin
                  coin_reject_d = 1'b1;
               end else begin
                  credit_d = coin_sum[5:0];
                  if (state_q == StIdle) begin
                     state_d = StCredit;
                  end
               end
            end
`ifdef VEND_TIMEOUT_EN
            if (tmo_hit) begin
               state_d = StChange;
            end
`endif
         end
         StVend: begin
            coin_reject_d = (bus.cash_in != 2'b00);
            if (bus.disp_ack && disp_req_q) begin
               credit_d = credit_q - ((item_q == 2'b01) ? PriceA : PriceB);
               state_d  = (credit_d == 6'd0) ? StIdle : StChange;
            end
         end
         StChange: begin
            coin_reject_d = (bus.cash_in != 2'b00);
            if (bus.chg_ack && chg_req_q) begin
               chg_taken = 1'b1;
               credit_d  = credit_q - ((chg_coin_q == 2'b10) ? 6'd10 : 6'd5);
               if (credit_d == 6'd0) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic, computed from the next state so the outputs are registered
   always_comb begin
      disp_req_d  = (state_d == StVend);
      disp_item_d = disp_req_d ? item_d : 2'b00;
      // Dropping for the ack cycle guarantees a one-cycle gap between coins.
      chg_req_d   = (state_d == StChange) && !chg_taken;
      chg_coin_d  = 2'b00;
      if (chg_req_d) begin
         chg_coin_d = (credit_d >= 6'd10) ? 2'b10 : 2'b01;
      end
   end

   assign bus.present_state = state_q;
   assign bus.credit        = credit_q;
   assign bus.disp_req      = disp_req_q;
   assign bus.disp_item     = disp_item_q;
   assign bus.chg_req       = chg_req_q;
   assign bus.chg_coin      = chg_coin_q;
   assign bus.coin_reject   = coin_reject_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the vending rules.
module tb_vend_controller;
   localparam int unsigned PA   = 10;
   localparam int unsigned PB   = 15;
   localparam int unsigned MAXC = 40;
   localparam int unsigned TMO  = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vend_if vif ();

   vend_controller #(
      .PRICE_A    (PA),
      .PRICE_B    (PB),
      .MAX_CREDIT (MAXC),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (vif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: phase 0 idle, 1 holding credit, 2 dispensing, 3 paying change.
   int m_st = 0, m_cr = 0, m_item = 0, m_cnt = 0;
   int m_dreq = 0, m_ditem = 0, m_creq = 0, m_ccoin = 0, m_rej = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_step(input int c, input int s, input int da, input int ca, input int r);
      int coin, nst, ncr, nitem, paid, bought;
      if (r == 0) begin
         m_st = 0; m_cr = 0; m_item = 0; m_cnt = 0;
         m_dreq = 0; m_ditem = 0; m_creq = 0; m_ccoin = 0; m_rej = 0;
         return;
      end
      coin   = (c == 1) ? 5 : (c == 2) ? 10 : (c == 3) ? 20 : 0;
      nst    = m_st;
      ncr    = m_cr;
      nitem  = m_item;
      paid   = 0;
      bought = 0;
      m_rej  = 0;
      if (m_st <= 1) begin
         if (m_st == 1 && s == 1 && m_cr >= PA) begin
            nitem = 1; nst = 2; bought = 1;
         end else if (m_st == 1 && s == 2 && m_cr >= PB) begin
            nitem = 2; nst = 2; bought = 1;
         end else if (s == 3 && m_cr > 0) begin
            nst = 3; bought = 1;
         end
         if (coin != 0) begin
            if (bought != 0 || m_cr + coin > MAXC) m_rej = 1;
            else begin
               ncr = m_cr + coin;
               if (nst == 0) nst = 1;
            end
         end
`ifdef VEND_TIMEOUT_EN
         if (m_st == 1 && c == 0 && s == 0) begin
            m_cnt++;
            if (m_cnt == TMO) begin
               nst = 3; m_cnt = 0;
            end
         end else m_cnt = 0;
`endif
      end else if (m_st == 2) begin
         m_rej = (c != 0) ? 1 : 0;
         if (da != 0 && m_dreq != 0) begin
            ncr = m_cr - ((m_item == 1) ? PA : PB);
            nst = (ncr == 0) ? 0 : 3;
         end
      end else begin
         m_rej = (c != 0) ? 1 : 0;
         if (ca != 0 && m_creq != 0) begin
            paid = 1;
            ncr  = m_cr - ((m_ccoin == 2) ? 10 : 5);
            if (ncr == 0) nst = 0;
         end
      end
      if (nst != 1) m_cnt = 0;
      m_st    = nst;
      m_cr    = ncr;
      m_item  = nitem;
      m_dreq  = (nst == 2) ? 1 : 0;
      m_ditem = (nst == 2) ? nitem : 0;
      m_creq  = (nst == 3 && paid == 0) ? 1 : 0;
      m_ccoin = (m_creq != 0) ? ((ncr >= 10) ? 2 : 1) : 0;
   endtask

   // Drive one cycle of inputs, advance the model and compare every output.
   task automatic step(input int c, input int s, input int da, input int ca, input int r);
      vif.cash_in  = 2'(c);
      vif.select   = 2'(s);
      vif.disp_ack = (da != 0);
      vif.chg_ack  = (ca != 0);
      rst_n        = (r != 0);
      @(posedge clk);
      model_step(c, s, da, ca, r);
      #1;
      check("state", int'(vif.present_state), m_st);
      check("credit", int'(vif.credit), m_cr);
      check("disp_req", int'(vif.disp_req), m_dreq);
      check("disp_item", int'(vif.disp_item), m_ditem);
      check("chg_req", int'(vif.chg_req), m_creq);
      check("chg_coin", int'(vif.chg_coin), m_ccoin);
      check("coin_reject", int'(vif.coin_reject), m_rej);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
   endtask

   // Acknowledge every visible change request for a bounded number of cycles.
   task automatic drain_change(input int n, output int n10, output int n5);
      n10 = 0;
      n5  = 0;
      for (int i = 0; i < n; i++) begin
         if (vif.chg_req) begin
            if (vif.chg_coin == 2'b10) n10++;
            else n5++;
            step(0, 0, 0, 1, 1);
         end else begin
            step(0, 0, 0, 0, 1);
         end
      end
   endtask

   initial begin
      int n10, n5;
      vif.cash_in  = 2'b00;
      vif.select   = 2'b00;
      vif.disp_ack = 1'b0;
      vif.chg_ack  = 1'b0;
      step(1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      check("reset_state", int'(vif.present_state), 0);
      check("reset_credit", int'(vif.credit), 0);

      // Test 1: 5 + 10, buy A, late ack, one 5Tk coin back
      step(1, 0, 0, 0, 1);
      step(2, 0, 0, 0, 1);
      check("t1_credit15", int'(vif.credit), 15);
      step(0, 1, 0, 0, 1);
      idle(3);
      check("t1_item", int'(vif.disp_item), 1);
      step(0, 0, 1, 0, 1);
      check("t1_credit5", int'(vif.credit), 5);
      check("t1_coin", int'(vif.chg_coin), 1);
      drain_change(6, n10, n5);
      check("t1_n5", n5, 1);
      check("t1_idle", int'(vif.present_state), 0);

      // Test 2: 20, buy B, one 5Tk coin back
      step(3, 0, 0, 0, 1);
      step(0, 2, 0, 0, 1);
      check("t2_item", int'(vif.disp_item), 2);
      step(0, 0, 1, 0, 1);
      check("t2_credit", int'(vif.credit), 5);
      drain_change(6, n10, n5);
      check("t2_n5", n5, 1);
      check("t2_idle", int'(vif.present_state), 0);

      // Test 3: overflow coin rejected, cancel refunds four 10Tk coins
      step(3, 0, 0, 0, 1);
      step(3, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      check("t3_reject", int'(vif.coin_reject), 1);
      check("t3_credit", int'(vif.credit), 40);
      step(0, 3, 0, 0, 1);
      drain_change(12, n10, n5);
      check("t3_n10", n10, 4);
      check("t3_credit0", int'(vif.credit), 0);

      // Test 4: short credit ignored, coin during VEND rejected
      step(1, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      check("t4_no_disp", int'(vif.disp_req), 0);
      check("t4_state", int'(vif.present_state), 1);
      step(2, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      check("t4_same_cycle_rej", int'(vif.coin_reject), 1);
      step(2, 0, 0, 0, 1);
      check("t4_vend_rej", int'(vif.coin_reject), 1);
      check("t4_vend_credit", int'(vif.credit), 15);
      step(0, 0, 1, 0, 1);
      drain_change(6, n10, n5);

      // Test 5: inactivity refund (or its absence)
      step(2, 0, 0, 0, 1);
`ifdef VEND_TIMEOUT_EN
      idle(TMO - 1);
      check("t5_not_yet", int'(vif.chg_req), 0);
      idle(1);
      check("t5_req", int'(vif.chg_req), 1);
      check("t5_coin", int'(vif.chg_coin), 2);
`else
      idle(2 * TMO);
      check("t5_held", int'(vif.present_state), 1);
      check("t5_no_req", int'(vif.chg_req), 0);
      step(0, 3, 0, 0, 1);
`endif
      drain_change(6, n10, n5);
      check("t5_idle", int'(vif.present_state), 0);

      // Test 6: reset mid-dispense abandons the sale
      step(3, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      check("t6_disp", int'(vif.disp_req), 1);
      step(0, 0, 0, 0, 0);
      check("t6_drop", int'(vif.disp_req), 0);
      check("t6_credit", int'(vif.credit), 0);
      step(0, 0, 1, 0, 1);
      check("t6_late_ack", int'(vif.present_state), 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int c, s, da, ca, r;
         c  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         da = ($urandom_range(0, 2) == 0) ? 1 : 0;
         ca = ($urandom_range(0, 2) == 0) ? 1 : 0;
         r  = ($urandom_range(0, 299) == 0) ? 0 : 1;
         step(c, s, da, ca, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
